// File: rtl/uart_tx_sched_if.sv
// Requester/transmitter bundle for uart_tx_sched; FRAME_CNT is present only
// when UART_TX_SCHED_STATS_EN is defined.
interface uart_tx_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;
  logic                          TX_EN;
  logic [DATA_WIDTH-1:0]         TX_DATA;
  logic                          TX_DONE;
  logic                          BUSY;
  logic [GW-1:0]                 GRANT_ID;
`ifdef UART_TX_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0]         FRAME_CNT;

  modport master (
    output REQ_VALID, REQ_DATA, TX_DONE,
    input  REQ_READY, TX_EN, TX_DATA, BUSY, GRANT_ID, FRAME_CNT
  );
  modport slave (
    input  REQ_VALID, REQ_DATA, TX_DONE,
    output REQ_READY, TX_EN, TX_DATA, BUSY, GRANT_ID, FRAME_CNT
  );
`else
  modport master (
    output REQ_VALID, REQ_DATA, TX_DONE,
    input  REQ_READY, TX_EN, TX_DATA, BUSY, GRANT_ID
  );
  modport slave (
    input  REQ_VALID, REQ_DATA, TX_DONE,
    output REQ_READY, TX_EN, TX_DATA, BUSY, GRANT_ID
  );
`endif
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler of NUM_REQ requesters onto one UART transmitter: grant 1 clk after REQ_VALID,
// TX_EN held until TX_DONE, then GAP_CYCLES idle; optional per-port frame counters via UART_TX_SCHED_STATS_EN.
module uart_tx_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic            CLK100MHZ,
  input  logic            RESET,
  uart_tx_sched_if.slave  io_bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_tx_en;
  logic                  w_tx_en_nxt;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [DATA_WIDTH-1:0] w_tx_data_nxt;
  logic [NUM_REQ-1:0]    r_ready;
  logic [NUM_REQ-1:0]    w_ready_nxt;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         w_grant_nxt;
  logic [GW-1:0]         r_last;
  logic [GW-1:0]         w_last_nxt;
  logic [CW-1:0]         r_gap;
  logic [CW-1:0]         w_gap_nxt;
  logic [GW:0]           w_pick;
  logic [GW-1:0]         w_win;

  // Scan from the farthest port down to last+1 so the nearest valid port is the final assignment.
  function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                          input logic [GW-1:0]      last);
    logic [GW:0] res;
    int          idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (vld[idx]) begin
        res = {1'b1, GW'(idx)};
      end
    end
    return res;
  endfunction

  assign w_pick = rr_pick(io_bus.REQ_VALID, r_last);
  assign w_win  = w_pick[GW-1:0];

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_ready   <= '0;
      r_grant   <= '0;
      r_last    <= GW'(NUM_REQ - 1);
      r_gap     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_ready   <= w_ready_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_gap     <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_en_nxt   = r_tx_en;
    w_tx_data_nxt = r_tx_data;
    w_ready_nxt   = '0;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_gap_nxt     = r_gap;
    case (r_state)
      IDLE: begin
        if (w_pick[GW]) begin
          w_state_nxt        = SEND;
          w_tx_en_nxt        = 1'b1;
          w_tx_data_nxt      = io_bus.REQ_DATA[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
          w_ready_nxt[w_win] = 1'b1;
          w_grant_nxt        = w_win;
          w_last_nxt         = w_win;
        end
      end
      SEND: begin
        if (io_bus.TX_DONE) begin
          w_state_nxt = GAP;
          w_tx_en_nxt = 1'b0;
          w_gap_nxt   = CW'(GAP_CYCLES);
        end
      end
      GAP: begin
        // Leave on the edge where the counter reaches zero; a zero load still spends one cycle here.
        w_gap_nxt = (r_gap == '0) ? '0 : r_gap - CW'(1);
        if (r_gap <= CW'(1)) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_en_nxt = 1'b0;
      end
    endcase
  end

  assign io_bus.TX_EN     = r_tx_en;
  assign io_bus.TX_DATA   = r_tx_data;
  assign io_bus.REQ_READY = r_ready;
  assign io_bus.GRANT_ID  = r_grant;
  assign io_bus.BUSY      = (r_state != IDLE);

`ifdef UART_TX_SCHED_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_frame_cnt;
  logic                     w_cnt_inc;

  assign w_cnt_inc = (r_state == SEND) && io_bus.TX_DONE;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      r_frame_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_frame_cnt[r_grant] <= r_frame_cnt[r_grant] + 16'd1;
    end
  end

  assign io_bus.FRAME_CNT = r_frame_cnt;
`endif
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: vector table plus scoreboard of expected grants checked on each TX_EN rise.
module tb_uart_tx_sched;
  localparam int DW  = 8;
  localparam int NR  = 4;
  localparam int GAP = 16;

  typedef struct {
    int         port;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] data;
    int          exp_port;
    logic [7:0]  exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_done;
  logic f_done = 1'b0;
  int   tx_len = 4;
  int   tx_cnt;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb[$];
  vec_t vt[8];

  logic prev_en, prev_done, seen_frame;
  int   low_cnt;
  bit   gap_chk = 1'b0;

  uart_tx_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  uart_tx_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GAP_CYCLES(GAP)) dut (
    .CLK100MHZ (clk),
    .RESET     (rst),
    .io_bus    (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.TX_DONE = m_done | f_done;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endfunction

  // Transmitter model: one-cycle TX_DONE after tx_len cycles of TX_EN.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= 0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (bus.TX_EN && !bus.TX_DONE) begin
        if (tx_cnt == tx_len - 1) begin
          m_done <= 1'b1;
          tx_cnt <= 0;
        end else begin
          tx_cnt <= tx_cnt + 1;
        end
      end else begin
        tx_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_en    <= 1'b0;
      prev_done  <= 1'b0;
      seen_frame <= 1'b0;
      low_cnt    <= 0;
    end else begin
      if (bus.TX_EN && !prev_en) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame_grant", bus.GRANT_ID, -1);
        end else begin
          e = sb.pop_front();
          chk("sb_grant_id", bus.GRANT_ID, e.port);
          chk("sb_tx_data", bus.TX_DATA, e.data);
        end
        if (gap_chk && seen_frame) chk("gap_low_cycles", low_cnt, GAP + 1);
        seen_frame <= 1'b1;
      end
      if (prev_en && prev_done) chk("txen_low_after_done", bus.TX_EN, 0);
      if (bus.REQ_READY != '0) chk("ready_onehot", $countones(bus.REQ_READY), 1);
      low_cnt   <= bus.TX_EN ? 0 : low_cnt + 1;
      prev_en   <= bus.TX_EN;
      prev_done <= bus.TX_DONE;
    end
  end

  task automatic push(input int p, input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    bus.REQ_VALID = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (bus.BUSY && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", bus.BUSY, 0);
  endtask

  task automatic wait_sb(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    int         n;
    logic [3:0] exp_rdy;

    vt[0] = '{4'b0001, 32'h0000_00A5, 0, 8'hA5};
    vt[1] = '{4'b0011, 32'h0000_3C11, 1, 8'h3C};
    vt[2] = '{4'b0011, 32'h0000_5E22, 0, 8'h22};
    vt[3] = '{4'b1000, 32'h7F00_0000, 3, 8'h7F};
    vt[4] = '{4'b1001, 32'h8000_0001, 0, 8'h01};
    vt[5] = '{4'b0110, 32'h00C3_B400, 1, 8'hB4};
    vt[6] = '{4'b0100, 32'h00FF_0000, 2, 8'hFF};
    vt[7] = '{4'b1111, 32'h5AA5_5AA5, 3, 8'h5A};

    bus.REQ_VALID = '0;
    bus.REQ_DATA  = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", bus.TX_EN, 0);
    chk("rst_tx_data", bus.TX_DATA, 0);
    chk("rst_req_ready", bus.REQ_READY, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_grant_id", bus.GRANT_ID, 0);
    rst = 1'b0;
    @(negedge clk);

    // TX_DONE while idle must not start anything.
    f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    chk("idle_done_busy", bus.BUSY, 0);
    chk("idle_done_txen", bus.TX_EN, 0);

    foreach (vt[i]) begin
      bus.REQ_DATA  = vt[i].data;
      bus.REQ_VALID = vt[i].mask;
      push(vt[i].exp_port, vt[i].exp_data);
      exp_rdy = 4'(1 << vt[i].exp_port);
      @(posedge clk);
      #1;
      chk("vec_txen_latency", bus.TX_EN, 1);
      chk("vec_ready_pulse", bus.REQ_READY, exp_rdy);
      chk("vec_busy", bus.BUSY, 1);
      bus.REQ_VALID = '0;
      bus.REQ_DATA  = ~vt[i].data;
      @(posedge clk);
      #1;
      chk("vec_ready_clear", bus.REQ_READY, 0);
      chk("vec_hold_data", bus.TX_DATA, vt[i].exp_data);
      chk("vec_hold_en", bus.TX_EN, 1);
      wait_idle(100);
    end

    // TX_DONE during GAP must not shorten the gap.
    @(negedge clk);
    bus.REQ_DATA  = 32'h0000_6900;
    bus.REQ_VALID = 4'b0010;
    push(1, 8'h69);
    @(posedge clk);
    #1;
    bus.REQ_VALID = '0;
    n = 0;
    @(negedge clk);
    while (bus.TX_EN && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    f_done = 1'b1;
    while (bus.BUSY && n < 100) begin
      n++;
      @(negedge clk);
      f_done = 1'b0;
    end
    f_done = 1'b0;
    chk("gap_len_ignore_done", n, GAP);

    // All ports valid continuously: 0,1,2,3,0 with GAP+1 low cycles between frames.
    do_reset();
    gap_chk = 1'b1;
    bus.REQ_DATA  = 32'h1312_1110;
    bus.REQ_VALID = 4'b1111;
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13); push(0, 8'h10);
    wait_sb(2000);
    bus.REQ_VALID = '0;
    wait_idle(100);

    // Ports 0 and 2 only: strict alternation.
    do_reset();
    bus.REQ_DATA  = 32'h00CC_00AA;
    bus.REQ_VALID = 4'b0101;
    push(0, 8'hAA); push(2, 8'hCC); push(0, 8'hAA); push(2, 8'hCC);
    wait_sb(2000);
    bus.REQ_VALID = '0;
    wait_idle(100);
    gap_chk = 1'b0;

    // Full-length frame at 868 clocks per bit.
    tx_len = 8680;
    bus.REQ_DATA  = 32'hE700_0000;
    bus.REQ_VALID = 4'b1000;
    push(3, 8'hE7);
    @(posedge clk);
    #1;
    bus.REQ_VALID = '0;
    n = 0;
    @(negedge clk);
    while (bus.TX_EN && n < 20000) begin
      n++;
      @(negedge clk);
    end
    chk_range("baud_frame_len", n, 10 * 868, 10 * 868 + 4);
    wait_idle(100);

    // Reset 300 cycles into a frame.
    do_reset();
    tx_len = 1000;
    bus.REQ_DATA  = 32'h003D_0000;
    bus.REQ_VALID = 4'b0100;
    push(2, 8'h3D);
    @(posedge clk);
    #1;
    bus.REQ_VALID = '0;
    repeat (300) @(negedge clk);
    chk("pre_reset_txen", bus.TX_EN, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_txen", bus.TX_EN, 0);
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_ready", bus.REQ_READY, 0);
    chk("midrst_grant", bus.GRANT_ID, 0);
    @(negedge clk);
    rst = 1'b0;
    tx_len = 4;
    repeat (3) @(negedge clk);
    chk("postrst_no_ready", bus.REQ_READY, 0);
    bus.REQ_DATA  = 32'h00CC_00AA;
    bus.REQ_VALID = 4'b0101;
    push(0, 8'hAA);
    @(posedge clk);
    #1;
    chk("postrst_first_grant", bus.REQ_READY, 4'b0001);
    bus.REQ_VALID = '0;
    wait_idle(100);

`ifdef UART_TX_SCHED_STATS_EN
    do_reset();
    bus.REQ_DATA  = 32'h0000_5500;
    bus.REQ_VALID = 4'b0010;
    for (int k = 0; k < 20; k++) push(1, 8'h55);
    wait_sb(4000);
    bus.REQ_VALID = '0;
    wait_idle(100);
    chk("stats_port0", bus.FRAME_CNT[15:0], 0);
    chk("stats_port1", bus.FRAME_CNT[31:16], 20);
    chk("stats_port2", bus.FRAME_CNT[47:32], 0);
    chk("stats_port3", bus.FRAME_CNT[63:48], 0);
`endif

    chk("sb_empty_at_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
